pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised pipeline stage register, successor to the fixed EX/MEM latch.
//   Carries a data payload and a control bundle between any two pipeline stages.
//   Adds valid/ready handshake, flush-to-bubble, an optional 2-entry skid buffer,
//   and a bubble counter for the debug unit. Advances only on debug-step cycles.
// PARAMETERS
//   NB_DATA  32  payload width (alu result, branch addr, etc. concatenated)
//   NB_CTRL  8   control bundle width (mem_read, mem_write, reg_write, word_size..)
//   SKID     1   1: 2-entry skid buffer, registered o_ready; 0: single entry
//   NB_CNT   16  bubble counter width
// PORTS
//   i_clk         in   1        clock; all state updates on falling edge
//   i_reset       in   1        synchronous, active-high reset
//   i_step        in   1        debug step enable; no state change when 0
//   i_flush       in   1        discard all held entries (branch/exception)
//   i_valid       in   1        upstream entry valid
//   o_ready       out  1        stage can accept an entry this step
//   i_data        in   NB_DATA  upstream payload
//   i_ctrl        in   NB_CTRL  upstream control bundle
//   o_valid       out  1        head entry valid
//   i_ready       in   1        downstream accepts head entry (0 = stall)
//   o_data        out  NB_DATA  head payload
//   o_ctrl        out  NB_CTRL  head control; forced to 0 when o_valid=0
//   o_occupancy   out  2        entries held (0..2; max 1 when SKID=0)
//   o_bubble_cnt  out  NB_CNT   bubbles delivered downstream, saturating
// BEHAVIOUR
//   - Reset (i_reset=1 at falling edge, overrides everything incl. i_step=0):
//     o_valid=0, o_data=0, o_ctrl=0, skid entry cleared, o_occupancy=0,
//     o_bubble_cnt=0, o_ready=1.
//   - Accept: i_step & i_valid & o_ready. Release: i_step & o_valid & i_ready.
//   - i_step=0: all state holds; handshakes are ignored (no accept/release).
//   - SKID=1 FSM, state = occupancy:
//     EMPTY: accept -> FULL (entry into head).
//     FULL:  accept&release -> FULL (new head); accept only -> SKID (entry into
//            skid reg); release only -> EMPTY.
//     SKID:  o_ready=0; release -> FULL (skid moves to head); else hold.
//     o_ready is registered: 1 in EMPTY/FULL, 0 in SKID.
//   - SKID=0: single entry; o_ready = ~o_valid | i_ready (combinational);
//     accept&release same step -> new head, stays valid.
//   - Latency: accepted entry appears on o_data/o_ctrl after the accepting edge
//     (1 step) when head empty or releasing; otherwise after skid drain.
//   - Flush (i_step=1): occupancy->0, o_valid=0, o_ctrl=0, skid invalidated, any
//     simultaneous accept dropped; o_data holds last value. Reset beats flush;
//     flush beats accept/release. Flush while i_step=0 has no effect.
//   - o_ctrl masked to 0 whenever o_valid=0 so no mem_write/reg_write fires.
//   - Bubble counter: +1 on each step with i_ready=1 and o_valid=0;
//     saturates at all-ones, no wrap; flush does not clear it.
//   - Reset mid-operation: all held entries lost, counter cleared.
// TESTING
//   1 Reset: i_reset=1, i_step=0 one edge -> o_valid=0, o_ctrl=0, occupancy=0,
//     o_ready=1, o_bubble_cnt=0.
//   2 Pass-through: step=1, i_ready=1, i_valid with data 0x11,0x22,0x33 ->
//     o_data 0x11,0x22,0x33 on next three edges, occupancy 1, o_ready=1.
//   3 Stall/skid (SKID=1): i_ready=0, push 0xA then 0xB -> occupancy 2, o_ready=0,
//     o_data=0xA; i_ready=1 -> 0xA, then 0xB released in order, none lost.
//   4 Flush with accept: occupancy 2, i_flush=1, i_valid=1 (0xC) -> occupancy 0,
//     o_valid=0, o_ctrl=0; 0xC not delivered.
//   5 Step gating: i_step=0 for 5 edges with i_valid=1, i_ready=1 -> outputs and
//     counter unchanged; i_step=1 -> single transfer.
//   6 Counter saturation (NB_CNT=2): 5 empty steps, i_ready=1 -> o_bubble_cnt
//     1,2,3,3,3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and a saturating bubble counter, advancing only on step cycles.
module pipe_stage_reg #(
  parameter int NB_DATA = 32,
  parameter int NB_CTRL = 8,
  parameter int SKID    = 1,
  parameter int NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [NB_CTRL-1:0] i_ctrl,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [1:0]         o_occupancy,
  output logic [NB_CNT-1:0]  o_bubble_cnt
);
  logic               r_valid, r_skid_valid, r_ready;
  logic [NB_DATA-1:0] r_data, r_skid_data;
  logic [NB_CTRL-1:0] r_ctrl, r_skid_ctrl;
  logic [NB_CNT-1:0]  r_cnt;
  logic               w_accept, w_release, w_bubble;
  assign o_ready      = (SKID != 0) ? r_ready : (~r_valid | i_ready);
  assign w_accept     = i_step & i_valid & o_ready;
  assign w_release    = i_step & r_valid & i_ready;
  assign w_bubble     = i_step & i_ready & ~r_valid;
  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_ctrl       = r_valid ? r_ctrl : '0;
  assign o_occupancy  = {1'b0, r_valid} + {1'b0, r_skid_valid};
  assign o_bubble_cnt = r_cnt;
  // the skid entry is only ever filled when SKID=1; with SKID=0 o_ready forbids that path
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
      r_data       <= '0;
      r_ctrl       <= '0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end else if (i_step) begin
      if (i_flush) begin
        r_valid      <= 1'b0;
        r_skid_valid <= 1'b0;
        r_ready      <= 1'b1;
      end else if (r_skid_valid) begin
        if (w_release) begin
          r_data       <= r_skid_data;
          r_ctrl       <= r_skid_ctrl;
          r_skid_valid <= 1'b0;
          r_ready      <= 1'b1;
        end
      end else if (w_accept && (!r_valid || w_release)) begin
        r_data  <= i_data;
        r_ctrl  <= i_ctrl;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_skid_data  <= i_data;
        r_skid_ctrl  <= i_ctrl;
        r_skid_valid <= 1'b1;
        r_ready      <= 1'b0;
      end else if (w_release) begin
        r_valid <= 1'b0;
      end
    end
  end
  always_ff @(negedge i_clk) begin
    if (i_reset) r_cnt <= '0;
    else if (w_bubble && !(&r_cnt)) r_cnt <= r_cnt + NB_CNT'(1);
  end
endmodule
